// File: rtl/timekeeper_core.sv
// Real-time clock core: BCD hh:mm:ss kept in 24-hour form, with a 12/24-hour display mapping.
// Optional alarm is enabled by defining TIMEKEEPER_ALARM_EN.
module timekeeper_core #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic       CLK100MHZ,
  input  logic       res_n,
  input  logic       pause,
  input  logic       inc_min,
  input  logic       inc_hour,
  input  logic       mode12,
`ifdef TIMEKEEPER_ALARM_EN
  input  logic [7:0] alarm_hh,
  input  logic [7:0] alarm_mm,
  input  logic       alarm_arm,
  input  logic       alarm_ack,
  output logic       alarm,
`endif
  output logic [3:0] hours1,
  output logic [3:0] hours2,
  output logic [3:0] mins1,
  output logic [3:0] mins2,
  output logic [3:0] secs1,
  output logic [3:0] secs2,
  output logic       pm,
  output logic       sec_tick
);

  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

  function automatic logic [6:0] bcd2bin(input logic [7:0] bcd);
    return 7'(bcd[7:4]) * 7'd10 + 7'(bcd[3:0]);
  endfunction

  function automatic logic [7:0] bin2bcd(input logic [6:0] bin);
    return {4'(bin / 7'd10), 4'(bin % 7'd10)};
  endfunction

  // Increments are at most 2, so one conditional subtract keeps the value in range
  function automatic logic [6:0] add_mod(input logic [6:0] v, input logic [1:0] a,
                                         input logic [6:0] m);
    logic [6:0] s;
    s = v + 7'(a);
    if (s >= m) s = s - m;
    return s;
  endfunction

  logic [DIV_W-1:0] r_div;
  logic [7:0]       r_hour, r_min, r_sec, r_disp_hour;
  logic             r_pm, r_sec_tick;

  logic [DIV_W-1:0] w_div_nxt;
  logic             w_tick, w_sec_carry, w_min_carry;
  logic [6:0]       w_hour_bin, w_min_bin, w_sec_bin;
  logic [6:0]       w_hour_nxt, w_min_nxt, w_sec_nxt, w_disp_hour;

  // Divider and next-time arithmetic; tick and manual increments are summed
  always_comb begin
    w_tick      = ~pause & (r_div == DIV_MAX);
    w_div_nxt   = r_div;
    if (!pause) w_div_nxt = w_tick ? '0 : r_div + DIV_W'(1);
    w_hour_bin  = bcd2bin(r_hour);
    w_min_bin   = bcd2bin(r_min);
    w_sec_bin   = bcd2bin(r_sec);
    w_sec_carry = w_tick & (w_sec_bin == 7'd59);
    w_min_carry = w_sec_carry & (w_min_bin == 7'd59);
    w_sec_nxt   = add_mod(w_sec_bin, 2'(w_tick), 7'd60);
    w_min_nxt   = add_mod(w_min_bin, 2'(w_sec_carry) + 2'(inc_min), 7'd60);
    w_hour_nxt  = add_mod(w_hour_bin, 2'(w_min_carry) + 2'(inc_hour), 7'd24);
    w_disp_hour = w_hour_nxt;
    if (mode12) begin
      if (w_hour_nxt == 7'd0)       w_disp_hour = 7'd12;
      else if (w_hour_nxt > 7'd12)  w_disp_hour = w_hour_nxt - 7'd12;
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!res_n) begin
      r_div       <= '0;
      r_hour      <= '0;
      r_min       <= '0;
      r_sec       <= '0;
      r_disp_hour <= '0;
      r_pm        <= 1'b0;
      r_sec_tick  <= 1'b0;
    end else begin
      r_div       <= w_div_nxt;
      r_hour      <= bin2bcd(w_hour_nxt);
      r_min       <= bin2bcd(w_min_nxt);
      r_sec       <= bin2bcd(w_sec_nxt);
      r_disp_hour <= bin2bcd(w_disp_hour);
      r_pm        <= (w_hour_nxt >= 7'd12);
      r_sec_tick  <= w_tick;
    end
  end

`ifdef TIMEKEEPER_ALARM_EN
  logic r_alarm;
  logic w_alarm_hit;

  // Only a divider tick landing exactly on hh:mm:00 arms the flag
  always_comb begin
    w_alarm_hit = w_tick & alarm_arm & (w_sec_nxt == 7'd0) &
                  (bin2bcd(w_hour_nxt) == alarm_hh) & (bin2bcd(w_min_nxt) == alarm_mm);
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!res_n)           r_alarm <= 1'b0;
    else if (alarm_ack)   r_alarm <= 1'b0;
    else if (w_alarm_hit) r_alarm <= 1'b1;
  end

  assign alarm = r_alarm;
`endif

  assign hours1   = r_disp_hour[7:4];
  assign hours2   = r_disp_hour[3:0];
  assign mins1    = r_min[7:4];
  assign mins2    = r_min[3:0];
  assign secs1    = r_sec[7:4];
  assign secs2    = r_sec[3:0];
  assign pm       = r_pm;
  assign sec_tick = r_sec_tick;

endmodule

// File: tb/tb_timekeeper_core.sv
// Directed self-checking bench for timekeeper_core at TICK_DIV=4.
module tb_timekeeper_core;

  logic       clk;
  logic       res_n, pause, inc_min, inc_hour, mode12;
  logic [3:0] hours1, hours2, mins1, mins2, secs1, secs2;
  logic       pm, sec_tick;
`ifdef TIMEKEEPER_ALARM_EN
  logic [7:0] alarm_hh, alarm_mm;
  logic       alarm_arm, alarm_ack, alarm;
`endif

  int checks = 0;
  int errors = 0;
  int ticks;

  timekeeper_core #(.TICK_DIV(4)) dut (
    .CLK100MHZ (clk),
    .res_n     (res_n),
    .pause     (pause),
    .inc_min   (inc_min),
    .inc_hour  (inc_hour),
    .mode12    (mode12),
`ifdef TIMEKEEPER_ALARM_EN
    .alarm_hh  (alarm_hh),
    .alarm_mm  (alarm_mm),
    .alarm_arm (alarm_arm),
    .alarm_ack (alarm_ack),
    .alarm     (alarm),
`endif
    .hours1    (hours1),
    .hours2    (hours2),
    .mins1     (mins1),
    .mins2     (mins2),
    .secs1     (secs1),
    .secs2     (secs2),
    .pm        (pm),
    .sec_tick  (sec_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string      name;
    logic       rst_n, pause, im, ih, m12;
    int         reps;
    logic [23:0] t;
    logic       pm, tk;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(input string n, input logic r, input logic p, input logic im,
                              input logic ih, input logic m12, input int reps,
                              input logic [23:0] t, input logic e_pm, input logic tk);
    vec_t v;
    v.name = n; v.rst_n = r; v.pause = p; v.im = im; v.ih = ih; v.m12 = m12;
    v.reps = reps; v.t = t; v.pm = e_pm; v.tk = tk;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string name, input logic [23:0] t, input logic e_pm, input logic tk);
    logic [23:0] act_t;
    act_t = {hours1, hours2, mins1, mins2, secs1, secs2};
    checks++;
    if (act_t !== t || pm !== e_pm || sec_tick !== tk) begin
      errors++;
      $display("FAIL %s: got %h pm=%b tick=%b, expected %h pm=%b tick=%b",
               name, act_t, pm, sec_tick, t, e_pm, tk);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reset, then load hh:mm through increments with the clock paused (divider stays 0)
  task automatic set_time(input int h, input int m);
    res_n = 1'b0; pause = 1'b1; inc_min = 1'b0; inc_hour = 1'b0;
    step();
    res_n = 1'b1;
    inc_hour = 1'b1;
    run(h);
    inc_hour = 1'b0;
    inc_min = 1'b1;
    run(m);
    inc_min = 1'b0;
  endtask

  initial begin
    res_n = 1'b0; pause = 1'b0; inc_min = 1'b1; inc_hour = 1'b1; mode12 = 1'b0;
`ifdef TIMEKEEPER_ALARM_EN
    alarm_hh = 8'h07; alarm_mm = 8'h30; alarm_arm = 1'b1; alarm_ack = 1'b0;
`endif
    run(2);
    chk("reset", 24'h000000, 1'b0, 1'b0);
`ifdef TIMEKEEPER_ALARM_EN
    chk_int("reset_alarm", int'(alarm), 0);
`endif

    // 240 cycles of free running: one minute
    inc_min = 1'b0; inc_hour = 1'b0; res_n = 1'b1;
    ticks = 0;
    for (int i = 0; i < 240; i++) begin
      step();
      if (sec_tick) ticks++;
    end
    chk("run240", 24'h000100, 1'b0, 1'b1);
    chk_int("tick_count", ticks, 60);

    // Pause freezes divider and time; inc still applies
    pause = 1'b1;
    ticks = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (sec_tick) ticks++;
    end
    chk("pause_hold", 24'h000100, 1'b0, 1'b0);
    chk_int("pause_ticks", ticks, 0);
    inc_min = 1'b1; step(); inc_min = 1'b0;
    chk("pause_inc_min", 24'h000200, 1'b0, 1'b0);
    pause = 1'b0;
    run(3);
    chk("resume_3", 24'h000200, 1'b0, 1'b0);
    step();
    chk("resume_tick", 24'h000201, 1'b0, 1'b1);

    // Increment and display-mode table, clock paused
    vecs[0]  = mk("t_reset",    0, 1, 0, 0, 0, 1,  24'h000000, 0, 0);
    vecs[1]  = mk("t_m12_h0",   1, 1, 0, 0, 1, 1,  24'h120000, 0, 0);
    vecs[2]  = mk("t_m24_h0",   1, 1, 0, 0, 0, 1,  24'h000000, 0, 0);
    vecs[3]  = mk("t_to_12",    1, 1, 0, 1, 0, 12, 24'h120000, 1, 0);
    vecs[4]  = mk("t_m12_h12",  1, 1, 0, 0, 1, 1,  24'h120000, 1, 0);
    vecs[5]  = mk("t_m12_h13",  1, 1, 0, 1, 1, 1,  24'h010000, 1, 0);
    vecs[6]  = mk("t_m24_h13",  1, 1, 0, 0, 0, 1,  24'h130000, 1, 0);
    vecs[7]  = mk("t_to_23",    1, 1, 0, 1, 0, 10, 24'h230000, 1, 0);
    vecs[8]  = mk("t_min_59",   1, 1, 1, 0, 0, 59, 24'h235900, 1, 0);
    vecs[9]  = mk("t_min_wrap", 1, 1, 1, 0, 0, 1,  24'h230000, 1, 0);
    vecs[10] = mk("t_hr_wrap",  1, 1, 0, 1, 0, 1,  24'h000000, 0, 0);
    vecs[11] = mk("t_both",     1, 1, 1, 1, 0, 1,  24'h010100, 0, 0);
    vecs[12] = mk("t_m12_h11",  1, 1, 0, 1, 1, 10, 24'h110100, 0, 0);
    vecs[13] = mk("t_m12_h12b", 1, 1, 0, 1, 1, 1,  24'h120100, 1, 0);
    vecs[14] = mk("t_rst_ovr",  0, 0, 1, 1, 0, 1,  24'h000000, 0, 0);
    for (int v = 0; v < 15; v++) begin
      res_n = vecs[v].rst_n; pause = vecs[v].pause; mode12 = vecs[v].m12;
      for (int r = 0; r < vecs[v].reps; r++) begin
        inc_min = vecs[v].im; inc_hour = vecs[v].ih;
        step();
      end
      inc_min = 1'b0; inc_hour = 1'b0; res_n = 1'b1;
      chk(vecs[v].name, vecs[v].t, vecs[v].pm, vecs[v].tk);
    end
    mode12 = 1'b0;

    // 23:59:59 rolls to midnight
    set_time(23, 59);
    chk("set_2359", 24'h235900, 1'b1, 1'b0);
    pause = 1'b0;
    run(236);
    chk("at_235959", 24'h235959, 1'b1, 1'b1);
    run(3);
    chk("hold_235959", 24'h235959, 1'b1, 1'b0);
    step();
    chk("midnight", 24'h000000, 1'b0, 1'b1);

    // Tick and inc_min in the same cycle, without then with minute carry
    set_time(5, 58);
    pause = 1'b0;
    run(236);
    chk("at_055859", 24'h055859, 1'b0, 1'b1);
    run(3);
    inc_min = 1'b1; step(); inc_min = 1'b0;
    chk("tick_inc_0558", 24'h050000, 1'b0, 1'b1);
    set_time(5, 59);
    pause = 1'b0;
    run(239);
    inc_min = 1'b1; step(); inc_min = 1'b0;
    chk("tick_inc_0559", 24'h060100, 1'b0, 1'b1);

`ifdef TIMEKEEPER_ALARM_EN
    set_time(7, 29);
    pause = 1'b0;
    run(236);
    chk_int("alarm_before", int'(alarm), 0);
    run(4);
    chk("alarm_time", 24'h073000, 1'b0, 1'b1);
    chk_int("alarm_set", int'(alarm), 1);
    run(8);
    chk_int("alarm_hold", int'(alarm), 1);
    alarm_ack = 1'b1; step(); alarm_ack = 1'b0;
    chk_int("alarm_ack", int'(alarm), 0);
    set_time(7, 30);
    chk("alarm_inc_time", 24'h073000, 1'b0, 1'b0);
    chk_int("alarm_inc_none", int'(alarm), 0);
    set_time(7, 29);
    pause = 1'b0;
    run(239);
    alarm_ack = 1'b1; step(); alarm_ack = 1'b0;
    chk_int("alarm_ack_wins", int'(alarm), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
